// File: rtl/vel_div_sched.sv
// vel_div_sched: shared radix-2 restoring divider with a two-channel
// round-robin scheduler (XY ratio and Z ratio).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   en                    clock enable; all registers hold when low
//   req_xy/did_xy/div_xy  XY request (4-phase level), dividend, divisor
//   req_z/did_z/div_z     Z request (4-phase level), dividend, narrow divisor
//   ack_xy, ack_z         result valid for the granted channel, held until req low
//   quo, rem, err         quotient, remainder, divide-by-zero flag of last op
//   busy                  high whenever the scheduler is not idle
//   gnt_z                 current owner: 0 = XY, 1 = Z
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a request; arbitration happens here
// LOAD   | latch granted operands, detect divisor == 0
// DIV    | one quotient bit per cycle, DID_W cycles
// DONE   | raise ack of the granted channel, update round-robin pointer
// REL    | hold ack until the granted request drops
module vel_div_sched #(
  parameter int DID_W = 26,
  parameter int DIV_W = 11,
  parameter int DZ_W  = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req_xy,
  input  logic [DID_W-1:0] did_xy,
  input  logic [DIV_W-1:0] div_xy,
  input  logic             req_z,
  input  logic [DID_W-1:0] did_z,
  input  logic [DZ_W-1:0]  div_z,
  output logic             ack_xy,
  output logic             ack_z,
  output logic [DID_W-1:0] quo,
  output logic [DIV_W-1:0] rem,
  output logic             err,
  output logic             busy,
  output logic             gnt_z
);

  localparam int CNT_W = $clog2(DID_W);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_DONE, S_REL} state_t;

  state_t             state, state_nxt;
  logic               last_z;
  logic [DID_W-1:0]   did_sr;
  logic [DIV_W-1:0]   dvs;
  logic [DIV_W:0]     prem;
  logic [CNT_W-1:0]   cnt;

  logic               grant_z;
  logic               req_gnt;
  logic [DID_W-1:0]   did_sel;
  logic [DIV_W-1:0]   div_sel;
  logic [DIV_W:0]     shifted;
  logic               q_bit;
  logic [DIV_W:0]     prem_nxt;
  logic [DID_W-1:0]   did_nxt;

  // On a tie the channel that was not served last wins.
  assign grant_z = req_z && (!req_xy || !last_z);
  assign req_gnt = gnt_z ? req_z : req_xy;
  assign did_sel = gnt_z ? did_z : did_xy;
  assign div_sel = gnt_z ? {{(DIV_W-DZ_W){1'b0}}, div_z} : div_xy;
  assign busy    = (state != S_IDLE);

  // One restoring step: the partial remainder carries one extra bit so the
  // shifted value (up to 2*divisor-1) never overflows before the compare.
  always_comb begin
    shifted  = {prem[DIV_W-1:0], did_sr[DID_W-1]};
    q_bit    = (shifted >= {1'b0, dvs});
    prem_nxt = q_bit ? (shifted - {1'b0, dvs}) : shifted;
    did_nxt  = {did_sr[DID_W-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_xy || req_z) state_nxt = S_LOAD;
      S_LOAD: state_nxt = (div_sel == '0) ? S_DONE : S_DIV;
      S_DIV:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE: state_nxt = S_REL;
      S_REL:  if (!req_gnt) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_z  <= 1'b0;
      last_z <= 1'b1;
      did_sr <= '0;
      dvs    <= '0;
      prem   <= '0;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      err    <= 1'b0;
      ack_xy <= 1'b0;
      ack_z  <= 1'b0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (req_xy || req_z) gnt_z <= grant_z;
        end
        S_LOAD: begin
          did_sr <= did_sel;
          dvs    <= div_sel;
          prem   <= '0;
          cnt    <= CNT_W'(DID_W - 1);
          if (div_sel == '0) begin
            quo <= '1;
            rem <= did_sel[DIV_W-1:0];
            err <= 1'b1;
          end else begin
            err <= 1'b0;
          end
        end
        S_DIV: begin
          did_sr <= did_nxt;
          prem   <= prem_nxt;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            quo <= did_nxt;
            rem <= prem_nxt[DIV_W-1:0];
          end
        end
        S_DONE: begin
          ack_xy <= !gnt_z;
          ack_z  <= gnt_z;
          last_z <= gnt_z;
        end
        S_REL: begin
          if (!req_gnt) begin
            ack_xy <= 1'b0;
            ack_z  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vel_div_sched.sv
module tb_vel_div_sched;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic        req_xy, req_z;
  logic [25:0] did_xy, did_z;
  logic [10:0] div_xy;
  logic [8:0]  div_z;
  logic        ack_xy, ack_z, err, busy, gnt_z;
  logic [25:0] quo;
  logic [10:0] rem;

  int vectors = 0;
  int miscompares = 0;

  vel_div_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_xy(req_xy), .did_xy(did_xy), .div_xy(div_xy),
    .req_z(req_z), .did_z(did_z), .div_z(div_z),
    .ack_xy(ack_xy), .ack_z(ack_z), .quo(quo), .rem(rem),
    .err(err), .busy(busy), .gnt_z(gnt_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; divide-by-zero returns all ones
  // and the low divisor-width bits of the dividend.
  function automatic logic [25:0] ref_q(input logic [25:0] d, input logic [10:0] v);
    return (v == 0) ? 26'h3FF_FFFF : d / v;
  endfunction
  function automatic logic [10:0] ref_r(input logic [25:0] d, input logic [10:0] v);
    logic [25:0] r;
    r = (v == 0) ? d : d % v;
    return r[10:0];
  endfunction

  task automatic issue(input bit z, input logic [25:0] d, input logic [10:0] v);
    if (z) begin did_z = d; div_z = v[8:0]; req_z = 1'b1; end
    else   begin did_xy = d; div_xy = v; req_xy = 1'b1; end
  endtask

  // Counts edges from the first edge that samples the request (inclusive)
  // to the edge after which ack is high. Owner's operands are scrambled
  // after they have been latched.
  task automatic wait_ack(input bit z, input int pause_at, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pause_at > 0 && i == pause_at) en = 1'b0;
      if (pause_at > 0 && i == pause_at + 5) en = 1'b1;
      if (i == 3) begin
        if (z) begin did_z = 26'($urandom); div_z = 9'($urandom); end
        else   begin did_xy = 26'($urandom); div_xy = 11'($urandom); end
      end
      if (z ? ack_z : ack_xy) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic finish_op(input bit z, input logic [25:0] d, input logic [10:0] v,
                           input bit chk_lat, input int pause_at);
    int cyc;
    int exp_lat;
    wait_ack(z, pause_at, cyc);
    chk("ack_seen", 32'(cyc > 0), 32'd1);
    exp_lat = ((v == 0) ? 3 : 29) + ((pause_at > 0) ? 5 : 0);
    if (chk_lat) chk("latency", 32'(cyc), 32'(exp_lat));
    chk("quo", 32'(quo), 32'(ref_q(d, v)));
    chk("rem", 32'(rem), 32'(ref_r(d, v)));
    chk("err", 32'(err), 32'(v == 0));
    chk("gnt_z", 32'(gnt_z), 32'(z));
    chk("other_ack", 32'(z ? ack_xy : ack_z), 32'd0);
    if (z) req_z = 1'b0; else req_xy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ack_drop", 32'(z ? ack_z : ack_xy), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
    chk("quo_hold", 32'(quo), 32'(ref_q(d, v)));
  endtask

  initial begin
    logic [25:0] d;
    logic [10:0] v;
    bit          z;
    int          cyc;

    rst_n = 1'b0; en = 1'b1; req_xy = 1'b0; req_z = 1'b0;
    did_xy = '0; div_xy = '0; did_z = '0; div_z = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'({ack_xy, ack_z}), 32'd0);
    chk("rst_quo", 32'(quo), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_gnt", 32'(gnt_z), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 26'd25000000, 11'd700);
    finish_op(0, 26'd25000000, 11'd700, 1, 0);

    issue(1, 26'd1250000, 11'd500);
    finish_op(1, 26'd1250000, 11'd500, 1, 0);

    issue(0, 26'd12345, 11'd0);
    finish_op(0, 26'd12345, 11'd0, 1, 0);

    issue(0, 26'd9999999, 11'd1234);
    finish_op(0, 26'd9999999, 11'd1234, 1, 10);

    // Reset in the middle of a division.
    issue(0, 26'd33554431, 11'd3);
    repeat (12) begin @(posedge clk); @(negedge clk); end
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ack", 32'({ack_xy, ack_z}), 32'd0);
    chk("mrst_quo", 32'(quo), 32'd0);
    chk("mrst_rem", 32'(rem), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    req_xy = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 26'd33554431, 11'd3);
    finish_op(0, 26'd33554431, 11'd3, 1, 0);

    // Simultaneous requests after reset: XY first, then Z even though XY
    // re-requests immediately, then XY again.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 26'd4000000, 11'd2047);
    issue(1, 26'd777777, 11'd511);
    finish_op(0, 26'd4000000, 11'd2047, 1, 0);
    issue(0, 26'd123456, 11'd77);
    finish_op(1, 26'd777777, 11'd511, 0, 0);
    finish_op(0, 26'd123456, 11'd77, 0, 0);

    // Requester withdraws before ack: one-cycle ack pulse, then idle.
    issue(0, 26'd5000, 11'd7);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    req_xy = 1'b0;
    wait_ack(0, 0, cyc);
    chk("viol_ack", 32'(cyc > 0), 32'd1);
    chk("viol_quo", 32'(quo), 32'(ref_q(26'd5000, 11'd7)));
    @(posedge clk);
    @(negedge clk);
    chk("viol_drop", 32'(ack_xy), 32'd0);
    chk("viol_busy", 32'(busy), 32'd0);

    for (int k = 0; k < 10; k++) begin
      z = 1'($urandom_range(0, 1));
      d = 26'($urandom);
      v = ($urandom_range(0, 7) == 0) ? 11'd0 :
          (z ? 11'($urandom_range(1, 511)) : 11'($urandom_range(1, 2047)));
      issue(z, d, v);
      finish_op(z, d, v, 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
